// File: rtl/mealy_table_fsm.sv
// Run-time programmable Mealy machine: a register-file transition/output table indexed by
// {state, in}, one transition per enabled cycle, with a sticky illegal-next flag and step counter.
module mealy_table_fsm #(
  parameter int NSTATES   = 4,
  parameter int IW        = 1,
  parameter int OW        = 3,
  parameter int RST_STATE = 0,
  parameter int CW        = 16,
  localparam int SW = $clog2(NSTATES),
  localparam int AW = SW + IW,
  localparam int DW = SW + OW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [IW-1:0] in,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [DW-1:0] cfg_data,
  output logic [OW-1:0] out,
  output logic [SW-1:0] state,
  output logic          err,
  output logic [CW-1:0] steps
);

  localparam int NENT = NSTATES << IW;
  localparam logic [SW:0]   NSTATES_L = (SW + 1)'(NSTATES);
  localparam logic [SW-1:0] RST_L     = SW'(RST_STATE);

  logic [DW-1:0] entryMem_q [NENT];
  logic [SW-1:0] state_q, state_d;
  logic          err_q, err_d;
  logic [CW-1:0] steps_q, steps_d;
  logic [DW-1:0] curEntry;
  logic [SW-1:0] fetchedNext;
  logic          cfgLegal;

  // The state register only ever holds a legal state, so the fetch index is always in range.
  always_comb begin
    curEntry    = entryMem_q[{state_q, in}];
    fetchedNext = curEntry[DW-1:OW];
    state_d     = state_q;
    err_d       = err_q;
    steps_d     = steps_q;
    if (en) begin
      if ({1'b0, fetchedNext} >= NSTATES_L) begin
        state_d = RST_L;
        err_d   = 1'b1;
      end else begin
        state_d = fetchedNext;
      end
      if (steps_q != '1) begin
        steps_d = steps_q + CW'(1);
      end
    end
  end

  assign cfgLegal = ({1'b0, cfg_addr[AW-1:IW]} < NSTATES_L);

  // Table writes land at the edge, so a step in the same cycle still sees the old entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RST_L;
      err_q   <= 1'b0;
      steps_q <= '0;
      for (int k = 0; k < NENT; k++) begin
        entryMem_q[k] <= {RST_L, {OW{1'b0}}};
      end
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      steps_q <= steps_d;
      if (cfg_we && cfgLegal) begin
        entryMem_q[cfg_addr] <= cfg_data;
      end
    end
  end

  assign out   = curEntry[OW-1:0];
  assign state = state_q;
  assign err   = err_q;
  assign steps = steps_q;

endmodule
